// File: rtl/rt_ibex_pcs_stack.sv
// rt_ibex_pcs_stack: pointer-addressed context-save stack for nested IRQ preemption
// with level tags, tail-chain push/pop, flush and sticky error flags.
module rt_ibex_pcs_stack #(
    parameter int NrSavedRegs = 9,
    parameter int DataWidth   = 32,
    parameter int Depth       = 8,
    parameter int LevelWidth  = 8,
    parameter int CntWidth    = $clog2(Depth + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  push_i,
    input  logic [LevelWidth-1:0]                 push_level_i,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0] push_data_i,
    input  logic                                  pop_i,
    input  logic                                  flush_i,
    input  logic                                  clear_err_i,
    output logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_o,
    output logic [LevelWidth-1:0]                 restore_level_o,
    output logic                                  restore_valid_o,
    output logic [LevelWidth-1:0]                 top_level_o,
    output logic [CntWidth-1:0]                   count_o,
    output logic                                  empty_o,
    output logic                                  full_o,
    output logic                                  overflow_o,
    output logic                                  underflow_o,
    output logic                                  order_err_o
);
    localparam int IdxWidth = $clog2(Depth);

    logic [NrSavedRegs-1:0][DataWidth-1:0] mem_q [Depth];
    logic [LevelWidth-1:0]                 lvl_q [Depth];
    logic [NrSavedRegs-1:0][DataWidth-1:0] rdata_q, rdata_d;
    logic [LevelWidth-1:0]                 rlevel_q, rlevel_d, top_level;
    logic [CntWidth-1:0]                   count_q, count_d;
    logic [IdxWidth-1:0]                   top_idx, wr_idx;
    logic rvalid_q, rvalid_d, ovf_q, ovf_d, unf_q, unf_d, ord_q, ord_d;
    logic is_empty, is_full, pop_ok, push_ok, ovf_set, unf_set, ord_set;

    always_comb begin
        is_empty  = count_q == '0;
        is_full   = count_q == CntWidth'(Depth);
        top_idx   = IdxWidth'(count_q - CntWidth'(1));
        top_level = is_empty ? '0 : lvl_q[top_idx];
        pop_ok    = !flush_i && pop_i && !is_empty;
        // a concurrent pop frees the top slot, so tail-chain pushes are legal when full
        push_ok   = !flush_i && push_i && (pop_i || !is_full);
        wr_idx    = pop_ok ? top_idx : IdxWidth'(count_q);
        unf_set   = !flush_i && pop_i && is_empty;
        ovf_set   = !flush_i && push_i && !pop_i && is_full;
        ord_set   = push_ok && !pop_i && !is_empty && push_level_i <= top_level;
        count_d   = flush_i ? '0 :
                    (push_ok && !pop_ok) ? count_q + CntWidth'(1) :
                    (pop_ok && !push_ok) ? count_q - CntWidth'(1) : count_q;
        rvalid_d  = pop_ok;
        rdata_d   = pop_ok ? mem_q[top_idx] : rdata_q;
        rlevel_d  = pop_ok ? lvl_q[top_idx] : rlevel_q;
        ovf_d     = (ovf_q && !clear_err_i) || ovf_set;
        unf_d     = (unf_q && !clear_err_i) || unf_set;
        ord_d     = (ord_q && !clear_err_i) || ord_set;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_idx] <= push_data_i;
            lvl_q[wr_idx] <= push_level_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rlevel_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ord_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rlevel_q <= rlevel_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            ord_q    <= ord_d;
        end
    end

    assign restore_data_o  = rdata_q;
    assign restore_level_o = rlevel_q;
    assign restore_valid_o = rvalid_q;
    assign top_level_o     = top_level;
    assign count_o         = count_q;
    assign empty_o         = is_empty;
    assign full_o          = is_full;
    assign overflow_o      = ovf_q;
    assign underflow_o     = unf_q;
    assign order_err_o     = ord_q;
endmodule

// File: tb/tb_rt_ibex_pcs_stack.sv
// tb_rt_ibex_pcs_stack: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the context stack.
module tb_rt_ibex_pcs_stack;
    localparam int D = 4, N = 2, W = 32, L = 8, C = $clog2(D + 1);
    typedef logic [N-1:0][W-1:0] ctx_t;

    logic clk = 1'b0, rst_i, push_i, pop_i, flush_i, clear_err_i;
    logic [L-1:0] push_level_i, restore_level_o, top_level_o;
    ctx_t push_data_i, restore_data_o;
    logic restore_valid_o, empty_o, full_o, overflow_o, underflow_o, order_err_o;
    logic [C-1:0] count_o;

    rt_ibex_pcs_stack #(.NrSavedRegs(N), .DataWidth(W), .Depth(D), .LevelWidth(L)) dut (
        .clk_i(clk), .rst_i(rst_i), .push_i(push_i), .push_level_i(push_level_i),
        .push_data_i(push_data_i), .pop_i(pop_i), .flush_i(flush_i), .clear_err_i(clear_err_i),
        .restore_data_o(restore_data_o), .restore_level_o(restore_level_o),
        .restore_valid_o(restore_valid_o), .top_level_o(top_level_o), .count_o(count_o),
        .empty_o(empty_o), .full_o(full_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .order_err_o(order_err_o));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    ctx_t dq[$];
    logic [L-1:0] lq[$];
    ctx_t e_rd = '0;
    logic [L-1:0] e_rl = '0;
    logic e_rv = 0, e_ovf = 0, e_unf = 0, e_ord = 0;

    function automatic ctx_t rnd_ctx();
        ctx_t c;
        for (int i = 0; i < N; i++) c[i] = $urandom;
        return c;
    endfunction

    function automatic logic [L-1:0] m_top();
        return lq.size() > 0 ? lq[lq.size()-1] : '0;
    endfunction

    function automatic void m_reset();
        dq.delete(); lq.delete();
        e_rd = '0; e_rl = '0; e_rv = 0; e_ovf = 0; e_unf = 0; e_ord = 0;
    endfunction

    // apply one cycle of stimulus, advance the model, sample 1 ns after the edge
    task automatic drive(input logic ps, input logic [L-1:0] pl, input ctx_t pd,
                         input logic pp, input logic fl, input logic ce);
        logic nu, no, nr;
        nu = 0; no = 0; nr = 0;
        push_i = ps; push_level_i = pl; push_data_i = pd;
        pop_i = pp; flush_i = fl; clear_err_i = ce;
        e_rv = 0;
        if (fl) begin
            dq.delete(); lq.delete();
        end else if (pp && dq.size() == 0) begin
            nu = 1;
            if (ps) begin dq.push_back(pd); lq.push_back(pl); end
        end else if (pp) begin
            e_rd = dq.pop_back(); e_rl = lq.pop_back(); e_rv = 1;
            if (ps) begin dq.push_back(pd); lq.push_back(pl); end
        end else if (ps) begin
            if (dq.size() == D) no = 1;
            else begin
                if (dq.size() > 0 && pl <= m_top()) nr = 1;
                dq.push_back(pd); lq.push_back(pl);
            end
        end
        e_ovf = (e_ovf && !ce) || no;
        e_unf = (e_unf && !ce) || nu;
        e_ord = (e_ord && !ce) || nr;
        @(posedge clk); #1;
        push_i = 0; pop_i = 0; flush_i = 0; clear_err_i = 0;
    endtask

    task automatic test_reset();
        total++; if (count_o !== '0 || empty_o !== 1 || full_o !== 0) begin bad++;
            $display("FAIL reset_count count=%0d empty=%b full=%b want 0/1/0", count_o, empty_o, full_o); end
        total++; if (restore_valid_o !== 0 || restore_data_o !== '0 || restore_level_o !== '0 || top_level_o !== '0) begin bad++;
            $display("FAIL reset_restore valid=%b data=%h lvl=%0d top=%0d want all 0", restore_valid_o, restore_data_o, restore_level_o, top_level_o); end
        total++; if ({overflow_o, underflow_o, order_err_o} !== 3'b000) begin bad++;
            $display("FAIL reset_err got=%b want=000", {overflow_o, underflow_o, order_err_o}); end
    endtask

    task automatic test_lifo();
        logic [L-1:0] lv [3] = '{8'd3, 8'd5, 8'd7};
        logic [L-1:0] want [3] = '{8'd7, 8'd5, 8'd3};
        for (int i = 0; i < 3; i++) drive(1, lv[i], rnd_ctx(), 0, 0, 0);
        total++; if (count_o !== 3 || top_level_o !== 7) begin bad++;
            $display("FAIL lifo_fill count=%0d top=%0d want 3/7", count_o, top_level_o); end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, '0, 1, 0, 0);
            total++; if (restore_valid_o !== 1 || restore_level_o !== want[i] || restore_data_o !== e_rd) begin bad++;
                $display("FAIL lifo_pop%0d valid=%b lvl=%0d data=%h want 1/%0d/%h", i, restore_valid_o, restore_level_o, restore_data_o, want[i], e_rd); end
            total++; if (count_o !== C'(2 - i)) begin bad++;
                $display("FAIL lifo_count%0d got=%0d want=%0d", i, count_o, 2 - i); end
        end
        drive(0, '0, '0, 0, 0, 0);
        total++; if (restore_valid_o !== 0 || empty_o !== 1 || restore_level_o !== 3) begin bad++;
            $display("FAIL lifo_after valid=%b empty=%b lvl=%0d want 0/1/3", restore_valid_o, empty_o, restore_level_o); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) drive(1, L'(i), rnd_ctx(), 0, 0, 0);
        drive(1, 8'd9, rnd_ctx(), 0, 0, 0);
        total++; if (full_o !== 1 || overflow_o !== 1 || count_o !== 4 || top_level_o !== 4) begin bad++;
            $display("FAIL ovf full=%b ovf=%b count=%0d top=%0d want 1/1/4/4", full_o, overflow_o, count_o, top_level_o); end
        drive(0, '0, '0, 1, 0, 0);
        total++; if (restore_valid_o !== 1 || restore_level_o !== 4 || restore_data_o !== e_rd) begin bad++;
            $display("FAIL ovf_pop valid=%b lvl=%0d data=%h want 1/4/%h", restore_valid_o, restore_level_o, restore_data_o, e_rd); end
        drive(0, '0, '0, 0, 1, 1);
        total++; if (overflow_o !== 0 || count_o !== 0) begin bad++;
            $display("FAIL ovf_clear ovf=%b count=%0d want 0/0", overflow_o, count_o); end
    endtask

    task automatic test_underflow();
        drive(0, '0, '0, 1, 0, 0);
        total++; if (underflow_o !== 1 || restore_valid_o !== 0 || count_o !== 0) begin bad++;
            $display("FAIL unf unf=%b valid=%b count=%0d want 1/0/0", underflow_o, restore_valid_o, count_o); end
        drive(0, '0, '0, 0, 0, 1);
        total++; if (underflow_o !== 0) begin bad++;
            $display("FAIL unf_clear got=%b want=0", underflow_o); end
        drive(1, 8'd2, rnd_ctx(), 1, 0, 0);
        total++; if (underflow_o !== 1 || restore_valid_o !== 0 || count_o !== 1 || top_level_o !== 2) begin bad++;
            $display("FAIL unf_push unf=%b valid=%b count=%0d top=%0d want 1/0/1/2", underflow_o, restore_valid_o, count_o, top_level_o); end
        drive(0, '0, '0, 0, 1, 1);
    endtask

    task automatic test_tail_chain();
        for (int i = 1; i <= 4; i++) drive(1, L'(i), rnd_ctx(), 0, 0, 0);
        drive(1, 8'd6, rnd_ctx(), 1, 0, 0);
        total++; if (restore_valid_o !== 1 || restore_level_o !== 4 || restore_data_o !== e_rd) begin bad++;
            $display("FAIL tail valid=%b lvl=%0d data=%h want 1/4/%h", restore_valid_o, restore_level_o, restore_data_o, e_rd); end
        total++; if (count_o !== 4 || top_level_o !== 6 || {overflow_o, order_err_o} !== 2'b00) begin bad++;
            $display("FAIL tail_state count=%0d top=%0d ovf/ord=%b want 4/6/00", count_o, top_level_o, {overflow_o, order_err_o}); end
        drive(0, '0, '0, 1, 0, 0);
        total++; if (restore_level_o !== 6 || restore_data_o !== e_rd) begin bad++;
            $display("FAIL tail_pop lvl=%0d data=%h want 6/%h", restore_level_o, restore_data_o, e_rd); end
        drive(0, '0, '0, 0, 1, 0);
    endtask

    task automatic test_order_flush();
        drive(1, 8'd5, rnd_ctx(), 0, 0, 0);
        drive(1, 8'd5, rnd_ctx(), 0, 0, 0);
        total++; if (order_err_o !== 1 || count_o !== 2) begin bad++;
            $display("FAIL order ord=%b count=%0d want 1/2", order_err_o, count_o); end
        drive(0, '0, '0, 1, 1, 0);
        total++; if (count_o !== 0 || restore_valid_o !== 0 || order_err_o !== 1) begin bad++;
            $display("FAIL flush count=%0d valid=%b ord=%b want 0/0/1", count_o, restore_valid_o, order_err_o); end
        drive(0, '0, '0, 0, 0, 1);
    endtask

    task automatic test_async_reset();
        drive(1, 8'd5, rnd_ctx(), 0, 0, 0);
        drive(1, 8'd2, rnd_ctx(), 0, 0, 0);
        pop_i = 1;
        #2 rst_i = 1;
        #1;
        m_reset();
        total++; if (count_o !== 0 || empty_o !== 1 || top_level_o !== 0 || order_err_o !== 0 || restore_data_o !== '0 || restore_level_o !== 0) begin bad++;
            $display("FAIL async_rst count=%0d empty=%b top=%0d ord=%b lvl=%0d want 0/1/0/0/0", count_o, empty_o, top_level_o, order_err_o, restore_level_o); end
        @(negedge clk); pop_i = 0;
        @(negedge clk); rst_i = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++; if (restore_valid_o !== 0 || count_o !== 0) begin bad++;
                $display("FAIL rst_release%0d valid=%b count=%0d want 0/0", i, restore_valid_o, count_o); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 5, L'($urandom_range(0, 12)), rnd_ctx(),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0);
            total++; if (count_o !== C'(dq.size()) || empty_o !== (dq.size() == 0) || full_o !== (dq.size() == D) || top_level_o !== m_top()) begin bad++;
                $display("FAIL rnd_state%0d count=%0d empty=%b full=%b top=%0d want %0d/%0d", n, count_o, empty_o, full_o, top_level_o, dq.size(), m_top()); end
            total++; if (restore_valid_o !== e_rv || restore_level_o !== e_rl || restore_data_o !== e_rd) begin bad++;
                $display("FAIL rnd_restore%0d valid=%b lvl=%0d data=%h want %b/%0d/%h", n, restore_valid_o, restore_level_o, restore_data_o, e_rv, e_rl, e_rd); end
            total++; if ({overflow_o, underflow_o, order_err_o} !== {e_ovf, e_unf, e_ord}) begin bad++;
                $display("FAIL rnd_err%0d got=%b want=%b", n, {overflow_o, underflow_o, order_err_o}, {e_ovf, e_unf, e_ord}); end
        end
    endtask

    initial begin
        rst_i = 1; push_i = 0; pop_i = 0; flush_i = 0; clear_err_i = 0;
        push_level_i = '0; push_data_i = '0;
        #12;
        test_reset();
        @(negedge clk); rst_i = 0;
        @(posedge clk); #1;
        test_lifo();
        test_overflow();
        test_underflow();
        test_tail_chain();
        test_order_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
